daa_readout_collector: RTL and testbench
========================================

Name: daa_readout_collector

Overview:
- Reader-side counterpart of the DAA MAC readout port.
- The MAC exposes its 31 bits of state through one 8-bit bus, time-multiplexed by a 2-bit select.
- This block freezes the MAC, walks the four select codes, captures each byte, and reassembles `result[9:0]`, `e_result[17:0]` and `exp_result[2:0]` into parallel registers.
- It sits between the MAC bus and the host/scan logic, and presents a start/busy/done handshake to the host.

Parameters:
- SETTLE_CYCLES, default 1, number of wait cycles after `sel_out` changes before `bus_in` is sampled (covers pad/mux settling); legal range 0..7.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one readout frame; sampled only in IDLE.
- `bus_in` in 8: MAC multiplexed output byte.
- `sel_out` out 2: drives the MAC InputSel.
- `freeze` out 1: high while reading; the top level gates the MAC enable with `~freeze`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse; the parallel outputs are valid from this cycle onward.
- `result` out 10: reassembled MAC result.
- `e_result` out 18: reassembled saved-LSB field.
- `exp_result` out 3: reassembled shift count.
- `frame_err` out 1: set with `done` if the framing check failed.

Behaviour:
- Reset (asynchronous, `rst_n`=0): all outputs are 0, the state is IDLE, the settle counter is 0. Reset mid-frame aborts the frame; no `done` is issued and the outputs are cleared.
- Byte map, fixed:
  - sel 0: `bus[7:0]` = `result[7:0]`.
  - sel 1: `bus[7:3]` = `e_result[4:0]`, `bus[2:0]` = `exp_result`.
  - sel 2: `bus[7:0]` = `e_result[12:5]`.
  - sel 3: `bus[6:5]` = `result[9:8]`, `bus[4:0]` = `e_result[17:13]`, `bus[7]` must be 0.
- FSM states: IDLE, FRZ, SEL0, SEL1, SEL2, SEL3, DONE.
  - IDLE: `sel_out`=0, `freeze`=0, `busy`=0. `start`=1 at an edge -> FRZ.
  - FRZ: `freeze`=1, `busy`=1. Exactly one cycle to let the MAC's in-flight enabled update complete -> SEL0.
  - SELk: `sel_out`=k, `freeze`=1. The settle counter starts at 0 on entry. Each edge with counter < SETTLE_CYCLES increments it. On the edge where counter == SETTLE_CYCLES, `bus_in` is captured into a byte shadow register k and the FSM moves to SEL(k+1); SEL3 moves to DONE.
  - DONE: one cycle. `done`=1, `freeze`=1, `busy`=1. The output registers are loaded from the shadows on entry, so they are visible while `done`=1. `frame_err` = shadow3 bit 7. Next state IDLE, which drops `freeze`/`busy` and returns `sel_out` to 0.
- Latency: a `start` edge to the `done`-high cycle = 1 + 4×(SETTLE_CYCLES+1) + 1 cycles; 10 cycles for SETTLE_CYCLES=1, 6 cycles for 0.
- Output registers hold their values until the next DONE or reset. They are never partially updated.
- `start` while not in IDLE is ignored; no queueing.
- `start` held high continuously gives back-to-back frames with one IDLE cycle between them.
- `sel_out` and `freeze` are registered; they are not a combinational function of `start`.

Decomposition:
- Shared package:
  - select code constants SEL_RES_LO=0, SEL_E_LO_EXP=1, SEL_E_MID=2, SEL_RES_HI_E_HI=3;
  - field widths RES_W=10, ERES_W=18, EXP_W=3;
  - the FSM state enum.
- One sub-module: daa_byte_unpack, purely combinational. It maps the four shadow bytes to {`result`, `e_result`, `exp_result`, `frame_err`}. It is reused by the bench's reference model.

Test Plan:
- Reset then idle: `rst_n` low 3 cycles, `start`=0 -> all outputs 0, `sel_out`=0, no `done`.
- Basic frame, SETTLE=1: bus model returns 0xA5 / 0x6B / 0x3C / 0x55 for sel 0..3; pulse `start` -> `done` 10 cycles later with:
  - `result`=0x2A5;
  - `e_result`=0x2A78D;
  - `exp_result`=3;
  - `frame_err`=0.
  - Also required: `freeze`=1 throughout and `sel_out` sequence 0,0,1,1,2,2,3,3.
- Framing error: sel 3 byte = 0x80 -> `frame_err`=1, `result[9:8]`=0, `e_result[17:13]`=0.
- Start during busy: second `start` pulse 3 cycles after the first -> exactly one `done`, no restart of the select sequence.
- Reset mid-frame: assert `rst_n`=0 while in SEL2 -> `freeze`, `busy`, `sel_out` go to 0 immediately, outputs 0, no `done`. The next `start` then completes normally.
- SETTLE_CYCLES=0 build: back-to-back frames with `start` held high -> `done` every 7 cycles, each frame's outputs match the bus model.

Source files
------------

// File: rtl/daa_readout_collector_pkg.sv
// Shared constants, field widths and FSM state type for the DAA readout collector.
// The MAC exposes 31 bits of state through an 8-bit bus addressed by a 2-bit select.
package daa_readout_collector_pkg;

  localparam logic [1:0] SEL_RES_LO      = 2'd0;
  localparam logic [1:0] SEL_E_LO_EXP    = 2'd1;
  localparam logic [1:0] SEL_E_MID       = 2'd2;
  localparam logic [1:0] SEL_RES_HI_E_HI = 2'd3;

  localparam int unsigned RES_W  = 10;
  localparam int unsigned ERES_W = 18;
  localparam int unsigned EXP_W  = 3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFrz  = 3'd1,
    StSel0 = 3'd2,
    StSel1 = 3'd3,
    StSel2 = 3'd4,
    StSel3 = 3'd5,
    StDone = 3'd6
  } state_e;

  // Select code driven to the MAC in a given state; idle and non-read states park on 0.
  function automatic logic [1:0] state_sel(input state_e s);
    case (s)
      StSel1:  return SEL_E_LO_EXP;
      StSel2:  return SEL_E_MID;
      StSel3:  return SEL_RES_HI_E_HI;
      default: return SEL_RES_LO;
    endcase
  endfunction

  function automatic state_e sel_advance(input state_e s);
    case (s)
      StSel0:  return StSel1;
      StSel1:  return StSel2;
      StSel2:  return StSel3;
      default: return StDone;
    endcase
  endfunction

endpackage

// File: rtl/daa_byte_unpack.sv
// Combinational reassembly of the four captured MAC bytes into the parallel fields.
// Bit 7 of the sel-3 byte is reserved-zero; a set bit flags a framing error.
module daa_byte_unpack
  import daa_readout_collector_pkg::*;
(
  input  logic [7:0]        byte0,
  input  logic [7:0]        byte1,
  input  logic [7:0]        byte2,
  input  logic [7:0]        byte3,
  output logic [RES_W-1:0]  result,
  output logic [ERES_W-1:0] e_result,
  output logic [EXP_W-1:0]  exp_result,
  output logic              frame_err
);

  assign result     = {byte3[6:5], byte0};
  assign e_result   = {byte3[4:0], byte2, byte1[7:3]};
  assign exp_result = byte1[2:0];
  assign frame_err  = byte3[7];

endmodule

// File: rtl/daa_readout_collector.sv
// Freezes the DAA MAC, walks the four select codes with a settle delay, captures each
// byte and publishes the reassembled fields atomically together with a done pulse.
module daa_readout_collector
  import daa_readout_collector_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        bus_in,
  output logic [1:0]        sel_out,
  output logic              freeze,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic [ERES_W-1:0] e_result,
  output logic [EXP_W-1:0]  exp_result,
  output logic              frame_err
);

  localparam logic [2:0] SettleMax = 3'(SETTLE_CYCLES);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0][7:0] shadow_q, shadow_d;
  logic            load;

  logic [1:0]        sel_q;
  logic              freeze_q;
  logic              done_q;
  logic [RES_W-1:0]  result_q;
  logic [ERES_W-1:0] e_result_q;
  logic [EXP_W-1:0]  exp_result_q;
  logic              frame_err_q;

  logic [RES_W-1:0]  unp_result;
  logic [ERES_W-1:0] unp_e_result;
  logic [EXP_W-1:0]  unp_exp_result;
  logic              unp_frame_err;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFrz;
      end
      StFrz: begin
        cnt_d   = '0;
        state_d = StSel0;
      end
      StSel0, StSel1, StSel2, StSel3: begin
        if (cnt_q < SettleMax) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          cnt_d                        = '0;
          shadow_d[state_sel(state_q)] = bus_in;
          state_d                      = sel_advance(state_q);
          load                         = (state_q == StSel3);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Unpack from next-state shadows so the last byte lands in the outputs on DONE entry.
  daa_byte_unpack u_unpack (
    .byte0      (shadow_d[0]),
    .byte1      (shadow_d[1]),
    .byte2      (shadow_d[2]),
    .byte3      (shadow_d[3]),
    .result     (unp_result),
    .e_result   (unp_e_result),
    .exp_result (unp_exp_result),
    .frame_err  (unp_frame_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      sel_q    <= SEL_RES_LO;
      freeze_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel_q    <= state_sel(state_d);
      freeze_q <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q     <= '0;
      e_result_q   <= '0;
      exp_result_q <= '0;
      frame_err_q  <= 1'b0;
    end else if (load) begin
      result_q     <= unp_result;
      e_result_q   <= unp_e_result;
      exp_result_q <= unp_exp_result;
      frame_err_q  <= unp_frame_err;
    end
  end

  assign sel_out    = sel_q;
  assign freeze     = freeze_q;
  assign busy       = freeze_q;
  assign done       = done_q;
  assign result     = result_q;
  assign e_result   = e_result_q;
  assign exp_result = exp_result_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_daa_readout_collector.sv
// Bench for daa_readout_collector: table vectors and random frames on a SETTLE=1 instance,
// back-to-back random frames on a SETTLE=0 instance, plus reset and busy-start sequences.
`timescale 1ns/1ps
module tb_daa_readout_collector;

  logic clk;
  logic rst_n;

  logic        start_a, freeze_a, busy_a, done_a, ferr_a;
  logic [7:0]  bus_a;
  logic [1:0]  sel_a;
  logic [9:0]  result_a;
  logic [17:0] eres_a;
  logic [2:0]  exp_a;
  logic [7:0]  bytes_a [4];

  logic        start_b, freeze_b, busy_b, done_b, ferr_b;
  logic [7:0]  bus_b;
  logic [1:0]  sel_b;
  logic [9:0]  result_b;
  logic [17:0] eres_b;
  logic [2:0]  exp_b;
  logic [7:0]  bytes_b [4];

  int checks = 0;
  int errors = 0;

  assign bus_a = bytes_a[sel_a];
  assign bus_b = bytes_b[sel_b];

  daa_readout_collector #(.SETTLE_CYCLES(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .bus_in     (bus_a),
    .sel_out    (sel_a),
    .freeze     (freeze_a),
    .busy       (busy_a),
    .done       (done_a),
    .result     (result_a),
    .e_result   (eres_a),
    .exp_result (exp_a),
    .frame_err  (ferr_a)
  );

  daa_readout_collector #(.SETTLE_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .bus_in     (bus_b),
    .sel_out    (sel_b),
    .freeze     (freeze_b),
    .busy       (busy_b),
    .done       (done_b),
    .result     (result_b),
    .e_result   (eres_b),
    .exp_result (exp_b),
    .frame_err  (ferr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] bytes;  // {sel3, sel2, sel1, sel0}
    logic [9:0]  res;
    logic [17:0] eres;
    logic [2:0]  expv;
    logic        ferr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Field extraction from the byte map, done with plain integer arithmetic.
  function automatic void ref_fields(input logic [31:0] bytes, output logic [9:0] r,
                                     output logic [17:0] e, output logic [2:0] x,
                                     output logic f);
    int unsigned b0, b1, b2, b3;
    b0 = int'(bytes[7:0]);
    b1 = int'(bytes[15:8]);
    b2 = int'(bytes[23:16]);
    b3 = int'(bytes[31:24]);
    r  = 10'(((b3 / 32) % 4) * 256 + b0);
    e  = 18'((b3 % 32) * 8192 + b2 * 32 + b1 / 8);
    x  = 3'(b1 % 8);
    f  = (b3 >= 128);
  endfunction

  task automatic run_frame_a(input string tag, input logic [31:0] bytes, input logic [9:0] er,
                             input logic [17:0] ee, input logic [2:0] ex, input logic ef);
    int n;
    bit seq_ok, frz_ok;
    for (int i = 0; i < 4; i++) bytes_a[i] = bytes[i*8 +: 8];
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 1;
    seq_ok = 1'b1;
    frz_ok = 1'b1;
    while (!done_a && n < 30) begin
      if (!freeze_a || !busy_a) frz_ok = 1'b0;
      if (n >= 2 && n <= 9 && sel_a != 2'((n - 2) / 2)) seq_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 10);
    check({tag, " freeze_busy"}, {31'd0, frz_ok}, 1);
    check({tag, " sel_seq"}, {31'd0, seq_ok}, 1);
    check({tag, " freeze_at_done"}, {freeze_a, busy_a}, 2'b11);
    check({tag, " result"}, result_a, er);
    check({tag, " e_result"}, eres_a, ee);
    check({tag, " exp_result"}, exp_a, ex);
    check({tag, " frame_err"}, ferr_a, ef);
    @(posedge clk); #1;
    check({tag, " idle_ctrl"}, {done_a, freeze_a, busy_a, sel_a}, 0);
    check({tag, " hold"}, {ferr_a, exp_a, result_a, eres_a}, {ef, ex, er, ee});
  endtask

  initial begin
    logic [31:0] rb;
    logic [9:0]  mr;
    logic [17:0] me;
    logic [2:0]  mx;
    logic        mf;
    int          n, dones, first;
    bit          ok;

    vecs[0] = '{bytes: 32'h55_3C_6B_A5, res: 10'h2A5, eres: 18'h2A78D, expv: 3'd3, ferr: 1'b0};
    vecs[1] = '{bytes: 32'h80_00_00_00, res: 10'h000, eres: 18'h00000, expv: 3'd0, ferr: 1'b1};
    vecs[2] = '{bytes: 32'hFF_FF_FF_FF, res: 10'h3FF, eres: 18'h3FFFF, expv: 3'd7, ferr: 1'b1};
    vecs[3] = '{bytes: 32'h7F_00_00_00, res: 10'h300, eres: 18'h3E000, expv: 3'd0, ferr: 1'b0};
    vecs[4] = '{bytes: 32'h00_00_F8_12, res: 10'h012, eres: 18'h0001F, expv: 3'd0, ferr: 1'b0};

    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bytes_a[i] = 8'h00;
      bytes_b[i] = 8'h00;
    end

    // Reset then idle.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {done_a, freeze_a, busy_a, sel_a, ferr_a, exp_a, result_a, eres_a}, 0);
    check("reset_b", {done_b, freeze_b, busy_b, sel_b, ferr_b, exp_b, result_b, eres_b}, 0);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_a || freeze_a || busy_a || sel_a != 2'd0 || result_a != 10'd0) ok = 1'b0;
    end
    check("idle_quiet", {31'd0, ok}, 1);

    for (int v = 0; v < 5; v++) begin
      run_frame_a($sformatf("vec%0d", v), vecs[v].bytes, vecs[v].res, vecs[v].eres,
                  vecs[v].expv, vecs[v].ferr);
    end

    for (int r = 0; r < 12; r++) begin
      rb = $urandom;
      ref_fields(rb, mr, me, mx, mf);
      run_frame_a($sformatf("rand%0d", r), rb, mr, me, mx, mf);
    end

    // Second start three cycles into a frame is ignored.
    for (int i = 0; i < 4; i++) bytes_a[i] = vecs[0].bytes[i*8 +: 8];
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    dones = 0;
    first = 0;
    for (int c = 1; c <= 25; c++) begin
      start_a = (c == 3);
      if (done_a) begin
        dones++;
        if (first == 0) first = c;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    check("busy_start_dones", dones, 1);
    check("busy_start_latency", first, 10);
    check("busy_start_result", eres_a, vecs[0].eres);

    // Reset while in SEL2 aborts the frame and clears outputs immediately.
    for (int i = 0; i < 4; i++) bytes_a[i] = vecs[2].bytes[i*8 +: 8];
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (sel_a != 2'd2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_sel2", {30'd0, sel_a}, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {done_a, freeze_a, busy_a, sel_a}, 0);
    check("midreset_out", {ferr_a, exp_a, result_a, eres_a}, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    check("midreset_no_done", dones, 0);
    run_frame_a("after_reset", vecs[0].bytes, vecs[0].res, vecs[0].eres, vecs[0].expv,
                vecs[0].ferr);

    // SETTLE_CYCLES=0 instance, start held high: done every 7 cycles.
    rb = $urandom;
    for (int i = 0; i < 4; i++) bytes_b[i] = rb[i*8 +: 8];
    start_b = 1'b1;
    for (int f = 0; f < 16; f++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done_b && n < 20);
      check($sformatf("b_period%0d", f), n, (f == 0) ? 6 : 7);
      ref_fields(rb, mr, me, mx, mf);
      check($sformatf("b_fields%0d", f), {ferr_b, exp_b, result_b, eres_b}, {mf, mx, mr, me});
      rb = $urandom;
      for (int i = 0; i < 4; i++) bytes_b[i] = rb[i*8 +: 8];
    end
    start_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
